// File: rtl/unified_mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch and data ports.
// Data has priority, bounded by a streak limit; flushed fetches are discarded and a missing ack times out.
module unified_mem_arbiter #(
   parameter int WORD         = 16,
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_req,
   input  logic [WORD-1:0] i_addr,
   input  logic            i_flush,
   output logic            i_ready,
   output logic [WORD-1:0] i_data,
   input  logic            d_read,
   input  logic            d_write,
   input  logic [WORD-1:0] d_addr,
   input  logic [WORD-1:0] d_wdata,
   output logic            d_ready,
   output logic [WORD-1:0] d_rdata,
   output logic            mem_read,
   output logic            mem_write,
   output logic [WORD-1:0] mem_addr,
   output logic [WORD-1:0] mem_wdata,
   input  logic [WORD-1:0] mem_rdata,
   input  logic            mem_ack,
   output logic            busy,
   output logic            timeout_err
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_IBUSY = 2'd1;
   localparam logic [1:0] ST_DBUSY = 2'd2;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
   localparam logic [7:0] TIMER_MAX  = 8'(TIMEOUT);

   logic [1:0]      state_q, state_d;
   logic [3:0]      streak_q, streak_d;
   logic [7:0]      timer_q, timer_d;
   logic            disc_q, disc_d;
   logic            busy_q, busy_d;
   logic            terr_q, terr_d;
   logic            i_ready_q, i_ready_d;
   logic            d_ready_q, d_ready_d;
   logic [WORD-1:0] i_data_q, i_data_d;
   logic [WORD-1:0] d_rdata_q, d_rdata_d;
   logic            mem_read_q, mem_read_d;
   logic            mem_write_q, mem_write_d;
   logic [WORD-1:0] mem_addr_q, mem_addr_d;
   logic [WORD-1:0] mem_wdata_q, mem_wdata_d;

   logic            d_req_s;
   logic            fetch_ok_s;
   logic [7:0]      timer_inc_s;

   // Arbitration, completion, flush-discard and timeout next-state logic.
   always_comb begin
      state_d     = state_q;
      streak_d    = streak_q;
      timer_d     = timer_q;
      disc_d      = disc_q;
      busy_d      = busy_q;
      terr_d      = terr_q;
      i_ready_d   = 1'b0;
      d_ready_d   = 1'b0;
      i_data_d    = i_data_q;
      d_rdata_d   = d_rdata_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      d_req_s     = d_read | d_write;
      fetch_ok_s  = i_req & ~i_flush;
      timer_inc_s = timer_q + 8'd1;

      case (state_q)
         ST_IDLE: begin
            // A flushed fetch is not pending, so data may proceed past the streak limit.
            if (d_req_s && (!fetch_ok_s || (streak_q < STREAK_MAX))) begin
               state_d     = ST_DBUSY;
               busy_d      = 1'b1;
               timer_d     = 8'd0;
               mem_read_d  = d_read;
               mem_write_d = d_write;
               mem_addr_d  = d_addr;
               mem_wdata_d = d_wdata;
               if (i_req) begin
                  if (streak_q != 4'hF) begin
                     streak_d = streak_q + 4'd1;
                  end else begin
                     streak_d = streak_q;
                  end
               end else begin
                  streak_d = 4'd0;
               end
            end else if (fetch_ok_s) begin
               state_d     = ST_IBUSY;
               busy_d      = 1'b1;
               timer_d     = 8'd0;
               disc_d      = 1'b0;
               streak_d    = 4'd0;
               mem_read_d  = 1'b1;
               mem_write_d = 1'b0;
               mem_addr_d  = i_addr;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_IBUSY, ST_DBUSY: begin
            if (mem_ack) begin
               state_d     = ST_IDLE;
               busy_d      = 1'b0;
               timer_d     = 8'd0;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               if (state_q == ST_IBUSY) begin
                  if (!disc_q && !i_flush) begin
                     i_data_d  = mem_rdata;
                     i_ready_d = 1'b1;
                  end else begin
                     i_data_d = i_data_q;
                  end
               end else begin
                  d_ready_d = 1'b1;
                  if (!mem_write_q) begin
                     d_rdata_d = mem_rdata;
                  end else begin
                     d_rdata_d = d_rdata_q;
                  end
               end
            end else if (timer_inc_s == TIMER_MAX) begin
               state_d     = ST_IDLE;
               busy_d      = 1'b0;
               timer_d     = 8'd0;
               terr_d      = 1'b1;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
            end else begin
               timer_d = timer_inc_s;
               if (state_q == ST_IBUSY) begin
                  disc_d = disc_q | i_flush;
               end else begin
                  disc_d = disc_q;
               end
            end
         end
         default: begin
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         streak_q    <= 4'd0;
         timer_q     <= 8'd0;
         disc_q      <= 1'b0;
         busy_q      <= 1'b0;
         terr_q      <= 1'b0;
         i_ready_q   <= 1'b0;
         d_ready_q   <= 1'b0;
         i_data_q    <= '0;
         d_rdata_q   <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         streak_q    <= streak_d;
         timer_q     <= timer_d;
         disc_q      <= disc_d;
         busy_q      <= busy_d;
         terr_q      <= terr_d;
         i_ready_q   <= i_ready_d;
         d_ready_q   <= d_ready_d;
         i_data_q    <= i_data_d;
         d_rdata_q   <= d_rdata_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
      end
   end

   assign i_ready     = i_ready_q;
   assign i_data      = i_data_q;
   assign d_ready     = d_ready_q;
   assign d_rdata     = d_rdata_q;
   assign mem_read    = mem_read_q;
   assign mem_write   = mem_write_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;
   assign busy        = busy_q;
   assign timeout_err = terr_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: hand-computed expectations checked with immediate assertions.
module tb_unified_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req, i_flush, d_read, d_write, mem_ack;
   logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic        i_ready, d_ready, mem_read, mem_write, busy, timeout_err;
   logic [15:0] i_data, d_rdata, mem_addr, mem_wdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.WORD(16), .MAX_D_STREAK(4), .TIMEOUT(8)) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
      .i_ready(i_ready), .i_data(i_data),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ready(d_ready), .d_rdata(d_rdata),
      .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .busy(busy), .timeout_err(timeout_err)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   int  d_before;
   int  d_after;
   bit  i_seen;

   initial begin
      reset = 1'b1; i_req = 1'b0; i_flush = 1'b0; d_read = 1'b0; d_write = 1'b0;
      mem_ack = 1'b0; i_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
      mem_rdata = 16'h0000;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
      chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
      chk("rst_i_data", {16'd0, i_data}, 32'd0);
      chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Fetch only, memory latency 2.
      step();
      i_req = 1'b1; i_addr = 16'h0010;
      step();
      chk("f1_mem_read", {31'd0, mem_read}, 32'd1);
      chk("f1_mem_addr", {16'd0, mem_addr}, 32'h0010);
      chk("f1_busy", {31'd0, busy}, 32'd1);
      step();
      chk("f2_mem_read", {31'd0, mem_read}, 32'd1);
      step();
      mem_ack = 1'b1; mem_rdata = 16'h6A01;
      step();
      chk("f4_i_ready", {31'd0, i_ready}, 32'd1);
      chk("f4_i_data", {16'd0, i_data}, 32'h6A01);
      chk("f4_busy", {31'd0, busy}, 32'd0);
      chk("f4_mem_read", {31'd0, mem_read}, 32'd0);
      mem_ack = 1'b0; i_req = 1'b0;
      step();
      chk("f5_i_ready_pulse", {31'd0, i_ready}, 32'd0);
      chk("f5_i_data_hold", {16'd0, i_data}, 32'h6A01);

      // Store and fetch requested in the same cycle.
      d_write = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF; i_req = 1'b1; i_addr = 16'h0020;
      step();
      chk("s_mem_write", {31'd0, mem_write}, 32'd1);
      chk("s_mem_read", {31'd0, mem_read}, 32'd0);
      chk("s_mem_addr", {16'd0, mem_addr}, 32'h0040);
      chk("s_mem_wdata", {16'd0, mem_wdata}, 32'hBEEF);
      mem_ack = 1'b1;
      step();
      chk("s_d_ready", {31'd0, d_ready}, 32'd1);
      chk("s_busy_idle", {31'd0, busy}, 32'd0);
      d_write = 1'b0; mem_ack = 1'b0;
      step();
      chk("s_fetch_read", {31'd0, mem_read}, 32'd1);
      chk("s_fetch_addr", {16'd0, mem_addr}, 32'h0020);
      mem_ack = 1'b1; mem_rdata = 16'h1111;
      step();
      chk("s_fetch_ready", {31'd0, i_ready}, 32'd1);
      chk("s_fetch_data", {16'd0, i_data}, 32'h1111);
      i_req = 1'b0; mem_ack = 1'b0;
      step();

      // Starvation guard: continuous loads against a pending fetch.
      d_read = 1'b1; d_addr = 16'h0080; i_req = 1'b1; i_addr = 16'h0030;
      d_before = 0; d_after = 0; i_seen = 1'b0;
      for (int n = 0; n < 16; n++) begin
         step();
         if (d_ready && !i_seen) d_before++;
         if (d_ready && i_seen) d_after++;
         if (i_ready) begin
            i_seen = 1'b1;
            i_req  = 1'b0;
         end
         if (d_after > 0) d_read = 1'b0;
         mem_ack   = busy;
         mem_rdata = (mem_addr == 16'h0030) ? 16'hC0DE : 16'hD0D0;
      end
      mem_ack = 1'b0;
      chk("st_d_before_fetch", 32'(d_before), 32'd4);
      chk("st_fetch_seen", {31'd0, i_seen}, 32'd1);
      chk("st_data_resumed", 32'(d_after), 32'd1);
      chk("st_i_data", {16'd0, i_data}, 32'hC0DE);
      chk("st_d_rdata", {16'd0, d_rdata}, 32'hD0D0);
      chk("st_idle", {31'd0, busy}, 32'd0);

      // Flush in the second I_BUSY cycle.
      i_req = 1'b1; i_addr = 16'h0050;
      step();
      chk("fl_granted", {31'd0, mem_read}, 32'd1);
      step();
      i_flush = 1'b1; i_req = 1'b0;
      step();
      i_flush = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1234;
      step();
      chk("fl_no_ready", {31'd0, i_ready}, 32'd0);
      chk("fl_data_kept", {16'd0, i_data}, 32'hC0DE);
      chk("fl_idle", {31'd0, busy}, 32'd0);
      mem_ack = 1'b0;
      step();
      chk("fl_no_late_ready", {31'd0, i_ready}, 32'd0);

      // Flush coincident with the ack.
      i_req = 1'b1; i_addr = 16'h0060;
      step();
      i_flush = 1'b1; i_req = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h5555;
      step();
      chk("fla_no_ready", {31'd0, i_ready}, 32'd0);
      chk("fla_data_kept", {16'd0, i_data}, 32'hC0DE);
      i_flush = 1'b0; mem_ack = 1'b0;

      // Flush in IDLE blocks that cycle's fetch grant only.
      i_req = 1'b1; i_addr = 16'h0070; i_flush = 1'b1;
      step();
      chk("fli_blocked", {31'd0, busy}, 32'd0);
      i_flush = 1'b0;
      step();
      chk("fli_granted", {16'd0, mem_addr}, 32'h0070);
      mem_ack = 1'b1; mem_rdata = 16'h7777;
      step();
      chk("fli_ready", {31'd0, i_ready}, 32'd1);
      chk("fli_data", {16'd0, i_data}, 32'h7777);
      i_req = 1'b0; mem_ack = 1'b0;
      step();

      // Timeout after 8 busy cycles, then a successful retry.
      chk("to_err_clear", {31'd0, timeout_err}, 32'd0);
      d_read = 1'b1; d_addr = 16'h0090;
      step();
      chk("to_c1_read", {31'd0, mem_read}, 32'd1);
      repeat (7) step();
      chk("to_c8_read", {31'd0, mem_read}, 32'd1);
      chk("to_c8_err", {31'd0, timeout_err}, 32'd0);
      step();
      chk("to_c9_dropped", {31'd0, mem_read}, 32'd0);
      chk("to_c9_idle", {31'd0, busy}, 32'd0);
      chk("to_c9_err", {31'd0, timeout_err}, 32'd1);
      chk("to_c9_no_ready", {31'd0, d_ready}, 32'd0);
      step();
      chk("to_retry_read", {31'd0, mem_read}, 32'd1);
      mem_ack = 1'b1; mem_rdata = 16'h9999;
      step();
      chk("to_retry_ready", {31'd0, d_ready}, 32'd1);
      chk("to_retry_data", {16'd0, d_rdata}, 32'h9999);
      chk("to_err_sticky", {31'd0, timeout_err}, 32'd1);
      d_read = 1'b0; mem_ack = 1'b0;
      step();

      // Reset asserted in D_BUSY, then a pending fetch after release.
      d_read = 1'b1; d_addr = 16'h00A0;
      step();
      chk("rm_dbusy", {31'd0, busy}, 32'd1);
      d_read = 1'b0; i_req = 1'b1; i_addr = 16'h00B0;
      #2 reset = 1'b1;
      #1;
      chk("rm_read_low", {31'd0, mem_read}, 32'd0);
      chk("rm_busy_low", {31'd0, busy}, 32'd0);
      chk("rm_err_cleared", {31'd0, timeout_err}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      step();
      chk("rm_no_ready", {31'd0, d_ready}, 32'd0);
      chk("rm_fetch_read", {31'd0, mem_read}, 32'd1);
      chk("rm_fetch_addr", {16'd0, mem_addr}, 32'h00B0);
      mem_ack = 1'b1; mem_rdata = 16'hBBBB;
      step();
      chk("rm_fetch_ready", {31'd0, i_ready}, 32'd1);
      chk("rm_fetch_data", {16'd0, i_data}, 32'hBBBB);
      i_req = 1'b0; mem_ack = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
